// File: rtl/lsu_dm_ctrl.sv
// lsu_dm_ctrl
//
// Load/store controller for a byte-addressed, little-endian data memory that
// exposes a single word-wide port. It takes one request at a time from the core
// and runs it through a small FSM (IDLE, RD, WR, RESP). Narrow stores
// (SH/SB) use read-modify-write. Narrow loads are lane-extracted and then
// sign- or zero-extended.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   req, op, addr,    request strobe, operation, byte address, store data
//   wdata             (sampled only while idle)
//   busy, done, err   status: busy outside IDLE, one-cycle done pulse,
//                     misalignment flag qualified by done
//   rdata             registered load result
//   dm_addr, dm_din,  word-aligned memory address, write data, write enable
//   dm_we
//   dm_dout           combinational memory read data
module lsu_dm_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       merge_reg, merge_next;
    logic              err_reg, err_next;
    logic [31:0]       rdata_reg, rdata_next;

    // Only the low ADDR_W address bits are meaningful; addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    // Alignment is judged on the request inputs at the moment they are
    // latched, so the very first transition can already go to RESP.
    logic misaligned_in;
    always_comb begin
        misaligned_in = 1'b0;
        case (op)
            OP_LW, OP_SW:         misaligned_in = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned_in = addr[0];
            default:              misaligned_in = 1'b0;
        endcase
    end

    logic is_load_reg;
    assign is_load_reg = (op_reg == OP_LW) || (op_reg == OP_LH) || (op_reg == OP_LHU) ||
                         (op_reg == OP_LB) || (op_reg == OP_LBU);

    // Per-lane read-modify-write merge. A lane takes store data when it is the
    // addressed byte (SB) or half of the addressed halfword (SH); every
    // other lane keeps the word just read from memory.
    logic [7:0]  dout_lane [4];
    logic [31:0] merged_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_data;

            assign dout_lane[gi] = dm_dout[8*gi +: 8];
            assign lane_hit  = (op_reg == OP_SB) ? (addr_reg[1:0] == 2'(gi))
                             : (op_reg == OP_SH) ? (addr_reg[1] == 1'(gi / 2))
                             : 1'b0;
            // In SH the lower lane of the pair receives the low data byte.
            assign lane_data = ((op_reg == OP_SH) && (gi % 2 == 1)) ? wdata_reg[15:8]
                                                                     : wdata_reg[7:0];
            assign merged_word[8*gi +: 8] = lane_hit ? lane_data : dm_dout[8*gi +: 8];
        end
    endgenerate

    logic [15:0] load_half;
    logic [7:0]  load_byte;
    assign load_half = addr_reg[1] ? dm_dout[31:16] : dm_dout[15:0];
    assign load_byte = dout_lane[addr_reg[1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= 3'b000;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
            merge_reg <= 32'h0;
            err_reg   <= 1'b0;
            rdata_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            merge_reg <= merge_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        merge_next = merge_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    op_next    = op;
                    addr_next  = addr[ADDR_W-1:0];
                    wdata_next = wdata;
                    err_next   = misaligned_in;
                    if (misaligned_in) begin
                        state_next = ST_RESP;
                    end else if (op == OP_SW) begin
                        state_next = ST_WR;
                    end else begin
                        // Loads read; SH/SB read first for the merge.
                        state_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (is_load_reg) begin
                    case (op_reg)
                        OP_LW:   rdata_next = dm_dout;
                        OP_LH:   rdata_next = {{16{load_half[15]}}, load_half};
                        OP_LHU:  rdata_next = {16'h0, load_half};
                        OP_LB:   rdata_next = {{24{load_byte[7]}}, load_byte};
                        default: rdata_next = {24'h0, load_byte};
                    endcase
                    state_next = ST_RESP;
                end else begin
                    merge_next = merged_word;
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                state_next = ST_RESP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the state alone, so an asynchronous reset
    // drops dm_we immediately and no write can commit.
    always_comb begin
        busy    = (state_reg != ST_IDLE);
        done    = (state_reg == ST_RESP);
        err     = (state_reg == ST_RESP) && err_reg;
        dm_we   = (state_reg == ST_WR);
        dm_addr = '0;
        dm_din  = 32'h0;
        if ((state_reg == ST_RD) || (state_reg == ST_WR)) begin
            dm_addr = {addr_reg[ADDR_W-1:2], 2'b00};
        end
        if (state_reg == ST_WR) begin
            dm_din = (op_reg == OP_SW) ? wdata_reg : merge_reg;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_lsu_dm_ctrl.sv
module tb_lsu_dm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, dm_we;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;

    lsu_dm_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Word-wide data memory with write bypass.
    logic [31:0] mem_w [0:255];
    assign dm_dout = dm_we ? dm_din : mem_w[dm_addr[9:2]];
    always @(posedge clk) if (dm_we) mem_w[dm_addr[9:2]] <= dm_din;

    // Reference model: byte array plus the last load result.
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] ref_rdata;

    int n_total = 0;
    int n_pass  = 0;

    int          got_cyc, we_cnt, done_cnt, err_stray, busy_bad;
    logic        got_err;
    logic [31:0] wr_addr_seen, wr_din_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request (called #1 after a rising edge with the DUT idle) and
    // watch the bus for 8 cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] w, input bit poke);
        req = 1'b1; op = o; addr = a; wdata = w;
        @(posedge clk); #1;
        req = 1'b0;
        got_cyc = 0; we_cnt = 0; done_cnt = 0; err_stray = 0; busy_bad = 0; got_err = 1'b0;
        wr_addr_seen = 32'h0; wr_din_seen = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (dm_we) begin
                we_cnt++;
                wr_addr_seen = {22'h0, dm_addr};
                wr_din_seen  = dm_din;
            end
            if (done) begin
                done_cnt++;
                if (got_cyc == 0) begin
                    got_cyc = c;
                    got_err = err;
                end
            end
            if (err && !done) err_stray++;
            if (c == 1 && !busy) busy_bad++;
            if (poke && c == 1) begin
                req = 1'b1; op = 3'b101; addr = 32'h30; wdata = 32'hCAFEF00D;
            end else if (poke && c == 2) begin
                req = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    // Predict from byte-level rules, run, and compare.
    task automatic exec(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] w, input bit poke);
        logic [9:0]  a10, base;
        logic        mis;
        int          lat;
        logic [15:0] half;
        logic [31:0] exp_din;
        a10  = a[9:0];
        base = {a10[9:2], 2'b00};
        mis  = ((o == 3'd0 || o == 3'd5) && a10[1:0] != 2'b00) ||
               ((o == 3'd1 || o == 3'd2 || o == 3'd6) && a10[0]);
        lat  = mis ? 1 : ((o == 3'd6 || o == 3'd7) ? 3 : 2);
        half = {ref_mem[a10 + 10'd1], ref_mem[a10]};
        if (!mis) begin
            case (o)
                3'd0: ref_rdata = {ref_mem[a10 + 10'd3], ref_mem[a10 + 10'd2],
                                   ref_mem[a10 + 10'd1], ref_mem[a10]};
                3'd1: ref_rdata = 32'($signed(half));
                3'd2: ref_rdata = 32'(half);
                3'd3: ref_rdata = 32'($signed(ref_mem[a10]));
                3'd4: ref_rdata = 32'(ref_mem[a10]);
                3'd5: for (int i = 0; i < 4; i++) ref_mem[a10 + 10'(i)] = w[8*i +: 8];
                3'd6: for (int i = 0; i < 2; i++) ref_mem[a10 + 10'(i)] = w[8*i +: 8];
                default: ref_mem[a10] = w[7:0];
            endcase
        end
        exp_din = {ref_mem[base + 10'd3], ref_mem[base + 10'd2],
                   ref_mem[base + 10'd1], ref_mem[base]};
        run_op(o, a, w, poke);
        $display("txn %s op=%0d addr=%h wdata=%h -> done@%0d err=%0b we=%0d rdata=%h",
                 name, o, a, w, got_cyc, got_err, we_cnt, rdata);
        check({name, " done_cycle"}, 32'(got_cyc), 32'(lat));
        check({name, " done_count"}, 32'(done_cnt), 32'd1);
        check({name, " err"}, {31'h0, got_err}, {31'h0, mis});
        check({name, " err_stray"}, 32'(err_stray), 32'd0);
        check({name, " busy"}, 32'(busy_bad), 32'd0);
        check({name, " we_count"}, 32'(we_cnt), (!mis && o >= 3'd5) ? 32'd1 : 32'd0);
        if (we_cnt > 0) begin
            check({name, " wr_addr"}, wr_addr_seen, {22'h0, base});
            check({name, " wr_din"}, wr_din_seen, exp_din);
        end
        check({name, " rdata"}, rdata, ref_rdata);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        for (int i = 0; i < 256; i++) mem_w[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        ref_rdata = 32'h0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst err", {31'h0, err}, 32'h0);
        check("rst dm_we", {31'h0, dm_we}, 32'h0);
        check("rst dm_addr", {22'h0, dm_addr}, 32'h0);
        check("rst dm_din", dm_din, 32'h0);
        check("rst rdata", rdata, 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store, then load back
        exec("t1_sw", 3'd5, 32'h10, 32'hDEADBEEF, 1'b0);
        exec("t1_lw", 3'd0, 32'h10, 32'h0, 1'b0);
        check("t1 rdata const", rdata, 32'hDEADBEEF);

        // Byte store merge
        exec("t2_sb", 3'd7, 32'h12, 32'h00000055, 1'b0);
        check("t2 sb din const", wr_din_seen, 32'hDE55BEEF);
        exec("t2_lw", 3'd0, 32'h10, 32'h0, 1'b0);
        check("t2 rdata const", rdata, 32'hDE55BEEF);

        // Narrow loads with extension
        exec("t3_sw", 3'd5, 32'h20, 32'h8001F0FF, 1'b0);
        exec("t3_lb", 3'd3, 32'h20, 32'h0, 1'b0);
        check("t3 lb const", rdata, 32'hFFFFFFFF);
        exec("t3_lbu", 3'd4, 32'h20, 32'h0, 1'b0);
        check("t3 lbu const", rdata, 32'h000000FF);
        exec("t3_lh", 3'd1, 32'h22, 32'h0, 1'b0);
        check("t3 lh const", rdata, 32'hFFFF8001);
        exec("t3_lhu", 3'd2, 32'h22, 32'h0, 1'b0);
        check("t3 lhu const", rdata, 32'h00008001);

        // Misaligned requests leave rdata alone
        exec("t4_lw_mis", 3'd0, 32'h21, 32'h0, 1'b0);
        exec("t4_sh_mis", 3'd6, 32'h23, 32'h1234, 1'b0);
        check("t4 rdata held", rdata, 32'h00008001);

        // Request during busy is ignored
        exec("t5_sw_init", 3'd5, 32'h30, 32'h11223344, 1'b0);
        exec("t5_sb_poke", 3'd7, 32'h30, 32'h000000AB, 1'b1);
        exec("t5_lw", 3'd0, 32'h30, 32'h0, 1'b0);
        check("t5 rdata const", rdata, 32'h112233AB);

        // Address wrap
        exec("wrap_sw", 3'd5, 32'h400, 32'h0BADF00D, 1'b0);
        exec("wrap_lw", 3'd0, 32'h0, 32'h0, 1'b0);
        check("wrap rdata const", rdata, 32'h0BADF00D);

        // Reset during WR
        exec("t6_sw_old", 3'd5, 32'h40, 32'hA5A5A5A5, 1'b0);
        req = 1'b1; op = 3'd5; addr = 32'h40; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        check("t6 we before reset", {31'h0, dm_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6 we", {31'h0, dm_we}, 32'h0);
        check("t6 busy", {31'h0, busy}, 32'h0);
        check("t6 done", {31'h0, done}, 32'h0);
        check("t6 err", {31'h0, err}, 32'h0);
        check("t6 dm_addr", {22'h0, dm_addr}, 32'h0);
        check("t6 dm_din", dm_din, 32'h0);
        check("t6 rdata", rdata, 32'h0);
        ref_rdata = 32'h0;
        @(posedge clk); #1;
        check("t6 we held low", {31'h0, dm_we}, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exec("t6_lw", 3'd0, 32'h40, 32'h0, 1'b0);
        check("t6 old contents", rdata, 32'hA5A5A5A5);

        // Randomized traffic against the byte model
        for (int n = 0; n < 80; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[9:6] = 4'h0;
            exec("rand", ro, ra, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
